seq_1011_tx: RTL and testbench
==============================

SEQ_1011_TX -- requirements
Module: seq_1011_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (legal range 1..32).
REQ-002 SHALL have parameter GAP_LEN, default 2, idle-zero cycles after each payload (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port tx_data  input  DATA_W  payload word, sampled only on handshake.
REQ-006 SHALL have port tx_valid  input  1  payload word available.
REQ-007 SHALL have port tx_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port out  output  1  registered serial line; carries preamble 1011, then payload.
REQ-009 SHALL have port busy  output  1  frame in progress (preamble, data or gap).
REQ-010 SHALL have port frame_done  output  1  single-cycle pulse marking end of payload.

Function
REQ-011 SHALL implement a 4-state FSM: IDLE, PRE, DATA, GAP, with a shared down/up bit counter sized for max(4, DATA_W, GAP_LEN).
REQ-012 SHALL assert tx_ready combinationally only in IDLE; tx_ready SHALL be 0 in PRE, DATA and GAP.
REQ-013 SHALL accept a word when tx_valid=1 and tx_ready=1 at a rising edge, capturing tx_data into an internal shift register and moving IDLE->PRE.
REQ-014 SHALL ignore tx_data and tx_valid whenever tx_ready=0; a held tx_valid is accepted on the first IDLE cycle.
REQ-015 SHALL drive out from a register; out SHALL be 0 in IDLE and GAP.
REQ-016 SHALL, in PRE, drive out = 1,0,1,1 on the four consecutive cycles following acceptance, then move PRE->DATA.
REQ-017 SHALL, in DATA, drive the captured word MSB first, one bit per cycle for DATA_W cycles, then move DATA->GAP.
REQ-018 SHALL hold GAP for exactly GAP_LEN cycles with out=0, then move GAP->IDLE.
REQ-019 SHALL make busy=1 exactly in PRE, DATA and GAP; a frame occupies 4+DATA_W+GAP_LEN busy cycles.
REQ-020 SHALL pulse frame_done high for exactly one cycle, the first GAP cycle.
REQ-021 SHALL allow back-to-back frames: with tx_valid held high, the next acceptance occurs on the single IDLE cycle after GAP, giving a period of 5+DATA_W+GAP_LEN cycles.
REQ-022 SHALL not change the payload being transmitted if tx_data changes after acceptance.
REQ-023 SHALL place the first preamble bit on out in the cycle after the accepting edge (latency 1 cycle).
REQ-024 SHALL treat any unused FSM encoding as IDLE on the next edge.

Reset
REQ-025 SHALL, while reset=0, asynchronously force state=IDLE, counter=0, shift register=0, out=0, busy=0, frame_done=0; tx_ready SHALL then read 1.
REQ-026 SHALL abort any frame in progress on reset assertion mid-frame; no remaining bits SHALL be emitted after reset releases.
REQ-027 SHALL accept a word no earlier than the first rising edge after reset deasserts.

Verification
REQ-028 SHALL be verified: DATA_W=8, GAP_LEN=2, accept 8'hA5 -> out = 1011 10100101 00, busy high 14 cycles, frame_done on cycle 13, tx_ready back at cycle 15.
REQ-029 SHALL be verified: tx_valid held high with 8'hFF then 8'h00 -> second preamble starts exactly 15 cycles after the first; out = 1011 11111111 00 0 1011 00000000 00.
REQ-030 SHALL be verified: tx_data changed to 8'h00 one cycle after accepting 8'h3C -> payload on out is 00111100.
REQ-031 SHALL be verified: reset=0 asserted during the third payload bit -> out, busy, frame_done drop to 0 immediately; after release out stays 0 and tx_ready=1 until a new handshake.
REQ-032 SHALL be verified: tx_valid pulsed high while busy=1 -> no acceptance, frame unchanged, the pulsed word never appears.
REQ-033 SHALL be verified: loopback into a 1011 sequence detector with payload 8'h00 -> detector fires exactly once per frame, on the last preamble bit.

Source files
------------

// File: rtl/seq_1011_tx.sv
// Serial frame transmitter: emits preamble 1011, then the captured payload MSB first,
// then GAP_LEN idle-zero cycles. Accepts a new word only while idle.
module seq_1011_tx #(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out,
    output logic              busy,
    output logic              frame_done
);

    localparam int MAX_A   = (DATA_W > 4) ? DATA_W : 4;
    localparam int MAX_CNT = (GAP_LEN > MAX_A) ? GAP_LEN : MAX_A;
    localparam int CW      = $clog2(MAX_CNT);

    localparam logic [CW-1:0] PRE_LAST  = CW'(3);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
    localparam logic [3:0]    PREAMBLE  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic              out_reg, out_next;
    logic              frame_done_reg, frame_done_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shreg_reg      <= '0;
            out_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shreg_reg      <= shreg_next;
            out_reg        <= out_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // cnt_reg indexes the bit currently on out; out_next is always the bit for the next cycle.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        shreg_next      = shreg_reg;
        out_next        = 1'b0;
        frame_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    state_next = PRE;
                    cnt_next   = '0;
                    shreg_next = tx_data;
                    out_next   = PREAMBLE[3];
                end
            end
            PRE: begin
                if (cnt_reg == PRE_LAST) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    out_next   = shreg_reg[DATA_W-1];
                    shreg_next = shreg_reg << 1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    out_next = PREAMBLE[2'd2 - cnt_reg[1:0]];
                end
            end
            DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    state_next      = GAP;
                    cnt_next        = '0;
                    frame_done_next = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    out_next   = shreg_reg[DATA_W-1];
                    shreg_next = shreg_reg << 1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign tx_ready   = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign out        = out_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seq_1011_tx.sv
// Directed bench for seq_1011_tx: per-cycle expected outputs are queued as stimulus is
// driven and compared on the falling edge; a 1011 detector watches the serial line.
module tb_seq_1011_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       out;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] sig;      // {out, busy, frame_done, tx_ready}
        logic       det_chk;
        logic       det_exp;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic       det_mode = 1'b0;
    logic [3:0] det_hist = 4'b0000;

    seq_1011_tx #(.DATA_W(8), .GAP_LEN(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .out       (out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] s, input logic de, input string tag);
        exp_t e;
        e.sig     = s;
        e.det_chk = det_mode;
        e.det_exp = de;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        push(4'b0001, 1'b0, tag);
    endtask

    // Queue the first n cycles of a frame carrying payload d.
    task automatic push_frame(input logic [7:0] d, input string tag, input int n);
        logic [3:0] pre;
        pre = 4'b1011;
        for (int k = 0; k < 14; k++) begin
            if (k < n) begin
                if (k < 4)
                    push({pre[3-k], 3'b100}, (k == 3), $sformatf("%s pre%0d", tag, k));
                else if (k < 12)
                    push({d[11-k], 3'b100}, 1'b0, $sformatf("%s bit%0d", tag, 11 - k));
                else if (k == 12)
                    push(4'b0110, 1'b0, $sformatf("%s gap0", tag));
                else
                    push(4'b0100, 1'b0, $sformatf("%s gap1", tag));
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One clock cycle: compare the queued expectation mid-cycle, return just after the next edge.
    task automatic tick();
        exp_t       e;
        logic [3:0] obs;
        logic       det;
        @(negedge clk);
        det_hist = {det_hist[2:0], out};
        det      = (det_hist == 4'b1011);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {out, busy, frame_done, tx_ready};
            checks++;
            assert (obs === e.sig) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.sig);
            end
            if (e.det_chk) begin
                checks++;
                assert (det === e.det_exp) else begin
                    errors++;
                    $error("FAIL %s det: observed %b expected %b", e.tag, det, e.det_exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", {out, busy, frame_done, tx_ready}, 4'b0001);
        reset = 1'b1;
        push_idle("post-reset idle");
        tick();

        // Single frame A5
        push_idle("A5 idle");
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        push_frame(8'hA5, "A5", 14);
        repeat (14) tick();
        push_idle("A5 ready");
        tick();
        push_idle("A5 idle2");
        tick();

        // Back-to-back FF then 00 with tx_valid held
        push_idle("b2b idle");
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        push_frame(8'hFF, "b2b FF", 14);
        tx_data = 8'h00;
        repeat (14) tick();
        push_idle("b2b slot");
        tick();
        push_frame(8'h00, "b2b 00", 14);
        tx_valid = 1'b0;
        repeat (14) tick();
        push_idle("b2b end");
        tick();

        // Data changed after acceptance
        push_idle("3C idle");
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        push_frame(8'h3C, "3C", 14);
        repeat (14) tick();
        push_idle("3C end");
        tick();

        // tx_valid pulsed while busy is ignored
        push_idle("5A idle");
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        push_frame(8'h5A, "5A", 14);
        repeat (4) tick();
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (9) tick();
        for (int i = 0; i < 3; i++) begin
            push_idle($sformatf("5A after %0d", i));
            tick();
        end

        // Reset asserted during the third payload bit
        push_idle("E7 idle");
        tx_data  = 8'hE7;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        push_frame(8'hE7, "E7", 6);
        repeat (6) tick();
        chk("E7 bit5 before reset", {out, busy, frame_done, tx_ready}, 4'b1100);
        #2;
        reset = 1'b0;
        #1;
        chk("E7 async reset", {out, busy, frame_done, tx_ready}, 4'b0001);
        @(posedge clk);
        #1;
        chk("E7 reset held", {out, busy, frame_done, tx_ready}, 4'b0001);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_idle($sformatf("E7 after release %0d", i));
            tick();
        end

        // Loopback into a 1011 detector, payload 00, two frames
        det_mode = 1'b1;
        push_idle("det idle");
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        push_frame(8'h00, "det f1", 14);
        repeat (14) tick();
        push_idle("det slot");
        tick();
        push_frame(8'h00, "det f2", 14);
        tx_valid = 1'b0;
        repeat (14) tick();
        push_idle("det end");
        tick();
        det_mode = 1'b0;

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard drain: observed %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
